// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, default NOP word and word-alignment helpers.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'h0000_0003;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr & WORD_ALIGN_MASK) == 32'd0;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// 8-bit wait counter for an outstanding memory access; expired flags the last permitted wait cycle.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_en) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: latches PC, runs the imem req/ack handshake, captures IR and PC+4.
// Flags misaligned PCs and memory timeouts; a flush mid-access drains the handshake before going idle.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        fetch_req,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc_plus4,
    output logic        ir_valid,
    output logic        fetch_done,
    output logic        busy,
    output logic        align_err,
    output logic        bus_err
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_addr, w_addr_nxt;
    logic [31:0]  r_ir, w_ir_nxt;
    logic [31:0]  r_pc4, w_pc4_nxt;
    logic         r_valid, w_valid_nxt;
    logic         r_done, w_done_nxt;
    logic         r_align, w_align_nxt;
    logic         r_bus, w_bus_nxt;
    logic         w_expired;

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (r_state == ST_IDLE),
        .i_en      ((r_state != ST_IDLE) && !imem_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= 32'd0;
            r_ir    <= NOP_WORD;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_align <= 1'b0;
            r_bus   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_ir    <= w_ir_nxt;
            r_pc4   <= w_pc4_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_align <= w_align_nxt;
            r_bus   <= w_bus_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_ir_nxt    = r_ir;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        w_align_nxt = r_align;
        w_bus_nxt   = r_bus;
        case (r_state)
            ST_IDLE: begin
                if (fetch_req) begin
                    w_bus_nxt = 1'b0;
                    if (is_word_aligned(pc)) begin
                        w_addr_nxt  = pc;
                        w_align_nxt = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_align_nxt = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // An ack on the expiry cycle still counts; flush on the ack edge discards the data.
                if (imem_ack) begin
                    w_state_nxt = ST_IDLE;
                    if (!flush) begin
                        w_ir_nxt    = imem_rdata;
                        w_pc4_nxt   = r_addr + 32'd4;
                        w_valid_nxt = 1'b1;
                        w_done_nxt  = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_bus_nxt   = 1'b1;
                end else if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_bus_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_ir_nxt    = NOP_WORD;
            w_valid_nxt = 1'b0;
        end
    end

    assign imem_req   = (r_state != ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign imem_addr  = r_addr;
    assign ir         = r_ir;
    assign pc_plus4   = r_pc4;
    assign ir_valid   = r_valid;
    assign fetch_done = r_done;
    assign align_err  = r_align;
    assign bus_err    = r_bus;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

    localparam int          TO  = 4;
    localparam logic [31:0] NOP = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'd0;
    logic        fetch_req = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] ir;
    logic [31:0] pc_plus4;
    logic        ir_valid;
    logic        fetch_done;
    logic        busy;
    logic        align_err;
    logic        bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_unit #(.TIMEOUT(TO), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .fetch_req  (fetch_req),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .pc_plus4   (pc_plus4),
        .ir_valid   (ir_valid),
        .fetch_done (fetch_done),
        .busy       (busy),
        .align_err  (align_err),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model: an access is either outstanding or not; 'm_keep' says whether its data is still wanted.
    logic [31:0] m_ir, m_pc4, m_addr;
    logic        m_valid, m_done, m_align, m_bus, m_active, m_keep;
    int          m_waited;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ir <= NOP; m_pc4 <= 32'd0; m_addr <= 32'd0;
            m_valid <= 1'b0; m_done <= 1'b0; m_align <= 1'b0; m_bus <= 1'b0;
            m_active <= 1'b0; m_keep <= 1'b0; m_waited <= 0;
        end else begin : model_step
            logic [31:0] n_ir, n_pc4, n_addr;
            logic        n_valid, n_done, n_align, n_bus, n_active, n_keep;
            int          n_waited;
            n_ir = m_ir; n_pc4 = m_pc4; n_addr = m_addr; n_valid = m_valid;
            n_done = 1'b0; n_align = m_align; n_bus = m_bus;
            n_active = m_active; n_keep = m_keep; n_waited = m_waited;
            if (m_active) begin
                if (imem_ack) begin
                    n_active = 1'b0;
                    if (m_keep && !flush) begin
                        n_ir = imem_rdata; n_pc4 = m_addr + 32'd4; n_valid = 1'b1; n_done = 1'b1;
                    end
                end else if (m_waited == TO - 1) begin
                    n_active = 1'b0; n_bus = 1'b1;
                end else begin
                    n_waited = m_waited + 1;
                    if (flush) n_keep = 1'b0;
                end
            end else if (fetch_req) begin
                n_bus = 1'b0;
                if (pc % 4 == 0) begin
                    n_addr = pc; n_align = 1'b0; n_active = 1'b1; n_keep = 1'b1; n_waited = 0;
                end else begin
                    n_align = 1'b1;
                end
            end
            if (flush) begin
                n_ir = NOP; n_valid = 1'b0;
            end
            m_ir <= n_ir; m_pc4 <= n_pc4; m_addr <= n_addr; m_valid <= n_valid;
            m_done <= n_done; m_align <= n_align; m_bus <= n_bus;
            m_active <= n_active; m_keep <= n_keep; m_waited <= n_waited;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("imem_req",   {31'd0, imem_req},   {31'd0, m_active});
            check("busy",       {31'd0, busy},       {31'd0, m_active});
            check("imem_addr",  imem_addr,           m_addr);
            check("ir",         ir,                  m_ir);
            check("pc_plus4",   pc_plus4,            m_pc4);
            check("ir_valid",   {31'd0, ir_valid},   {31'd0, m_valid});
            check("fetch_done", {31'd0, fetch_done}, {31'd0, m_done});
            check("align_err",  {31'd0, align_err},  {31'd0, m_align});
            check("bus_err",    {31'd0, bus_err},    {31'd0, m_bus});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fetch(input logic [31:0] addr);
        pc = addr; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) tick();
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_ir", ir, NOP);
        check("rst_pc_plus4", pc_plus4, 32'd0);
        check("rst_flags", {26'd0, busy, ir_valid, fetch_done, align_err, bus_err, imem_addr != 0}, 32'd0);
        reset = 1'b0;
        tick();

        // Zero-wait fetch
        start_fetch(32'h0000_0010);
        check("zw_req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h2002_0005;
        tick();
        imem_ack = 1'b0;
        check("zw_ir", ir, 32'h2002_0005);
        check("zw_pc4", pc_plus4, 32'h0000_0014);
        check("zw_done", {31'd0, fetch_done}, 32'd1);
        tick();
        check("zw_done_pulse", {31'd0, fetch_done}, 32'd0);

        // Misaligned PC, then aligned fetch with wait states and an ignored mid-REQ fetch_req
        start_fetch(32'h0000_0006);
        check("mis_align", {31'd0, align_err}, 32'd1);
        check("mis_req", {31'd0, imem_req}, 32'd0);
        check("mis_ir", ir, 32'h2002_0005);
        start_fetch(32'h0000_0100);
        check("ws_align_clr", {31'd0, align_err}, 32'd0);
        pc = 32'h0000_0200; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("ws_addr_stable", imem_addr, 32'h0000_0100);
        tick();
        check("ws_req_held", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h8C01_0004;
        tick();
        imem_ack = 1'b0;
        check("ws_ir", ir, 32'h8C01_0004);
        check("ws_pc4", pc_plus4, 32'h0000_0104);
        check("ws_idle", {31'd0, busy}, 32'd0);

        // Timeout with no ack
        start_fetch(32'h0000_0040);
        n = 0;
        while (imem_req && n < 20) begin
            n++;
            tick();
        end
        check("to_req_cycles", n, TO);
        check("to_bus_err", {31'd0, bus_err}, 32'd1);
        check("to_idle", {31'd0, busy}, 32'd0);

        // Flush in REQ, ack two cycles later
        start_fetch(32'h0000_0080);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_drain_req", {31'd0, imem_req}, 32'd1);
        check("fl_ir", ir, NOP);
        check("fl_valid", {31'd0, ir_valid}, 32'd0);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        imem_ack = 1'b0;
        check("fl_idle", {31'd0, busy}, 32'd0);
        check("fl_no_done", {31'd0, fetch_done}, 32'd0);
        check("fl_ir_nop", ir, NOP);

        // Flush and ack on the same edge
        start_fetch(32'h0000_0090);
        imem_ack = 1'b1; flush = 1'b1; imem_rdata = 32'h0000_1234;
        tick();
        imem_ack = 1'b0; flush = 1'b0;
        check("fa_idle", {31'd0, busy}, 32'd0);
        check("fa_no_done", {31'd0, fetch_done}, 32'd0);
        check("fa_ir", ir, NOP);

        // Address wrap
        start_fetch(32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'hABCD_0001;
        tick();
        imem_ack = 1'b0;
        check("wrap_pc4", pc_plus4, 32'd0);
        check("wrap_ir", ir, 32'hABCD_0001);

        // Reset mid-REQ
        start_fetch(32'h0000_0300);
        tick();
        #2 reset = 1'b1;
        #1;
        check("rr_req", {31'd0, imem_req}, 32'd0);
        check("rr_ir", ir, NOP);
        check("rr_pc4", pc_plus4, 32'd0);
        check("rr_flags", {27'd0, ir_valid, fetch_done, align_err, bus_err, imem_addr != 0}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            fetch_req  = ($urandom % 10) < 4;
            pc         = $urandom;
            if ($urandom % 8 != 0) pc[1:0] = 2'b00;
            flush      = ($urandom % 20) == 0;
            imem_ack   = imem_req && ($urandom % 4 == 0);
            imem_rdata = $urandom;
            tick();
        end
        fetch_req = 1'b0; flush = 1'b0; imem_ack = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
